// File: rtl/pmod_adc_pkg.sv
//------------------------------------------------------------------------------
// Module : pmod_adc_pkg
// Brief  : Shared constants and packetizer state encoding for the ADC path.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pmod_adc_pkg;

    localparam logic [7:0] SYNC_BYTE        = 8'hA5;
    localparam int         BYTES_PER_SAMPLE = 2;
    localparam int         SAMPLE_BITS      = 8 * BYTES_PER_SAMPLE;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_SEQ  = 3'd2,
        ST_SHI  = 3'd3,
        ST_SLO  = 3'd4,
        ST_CSUM = 3'd5
    } pkt_state_e;

endpackage

`default_nettype wire

// File: rtl/adc_sample_packetizer_if.sv
//------------------------------------------------------------------------------
// Module : adc_sample_packetizer_if
// Brief  : Sample intake strobe and byte-stream handshake toward fifo_interface.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface adc_sample_packetizer_if;
    import pmod_adc_pkg::*;

    logic                   sample_valid_i;
    logic [SAMPLE_BITS-1:0] sample_i;
    logic                   tx_busy_i;
    logic                   tx_data_rdy_o;
    logic [7:0]             tx_data_o;

    modport slave (
        input  sample_valid_i,
        input  sample_i,
        input  tx_busy_i,
        output tx_data_rdy_o,
        output tx_data_o
    );

    modport master (
        output sample_valid_i,
        output sample_i,
        output tx_busy_i,
        input  tx_data_rdy_o,
        input  tx_data_o
    );

endinterface

`default_nettype wire

// File: rtl/sample_fifo.sv
//------------------------------------------------------------------------------
// Module : sample_fifo
// Brief  : Synchronous DEPTH x WIDTH FIFO with occupancy count; no drop logic.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  wire logic             clk_i,
    input  wire logic             reset_ni,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] data_o,
    output logic      [AW:0]      count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign w_do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a write when a read frees a slot this cycle.
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign data_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/adc_sample_packetizer.sv
//------------------------------------------------------------------------------
// Module : adc_sample_packetizer
// Brief  : Buffers ADC samples and emits framed byte streams (sync, seq, data, xor).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module adc_sample_packetizer
    import pmod_adc_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int FRAME_N  = 4,
    parameter int DEPTH    = 16,
    parameter int GAP      = 2
) (
    input  wire logic               clk_i,
    input  wire logic               reset_ni,
    input  wire logic               enable_i,
    adc_sample_packetizer_if.slave  bus,
    output logic                    overflow_o,
    output logic [7:0]              drop_count_o,
    output logic                    frame_active_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(FRAME_N) + 1;
    localparam int GW = $clog2(GAP + 1);

    localparam logic [AW:0]   c_frame_n = (AW+1)'(FRAME_N);
    localparam logic [SW-1:0] c_last    = SW'(FRAME_N - 1);
    localparam logic [GW-1:0] c_gap     = GW'(GAP);

    pkt_state_e          state_q, state_d;
    logic [SAMPLE_W-1:0] sample_q;
    logic [7:0]          seq_q;
    logic [7:0]          csum_q;
    logic [SW-1:0]       smp_q;
    logic [GW-1:0]       gap_q;
    logic                tx_rdy_q;
    logic [7:0]          tx_data_q;
    logic                overflow_q;
    logic [7:0]          drop_q;

    logic                w_fire;
    logic                w_pop;
    logic                w_can_tx;
    logic                w_last;
    logic [7:0]          w_byte;
    logic                w_push_req;
    logic                w_push;
    logic                w_drop;
    logic [SAMPLE_W-1:0] w_fifo_data;
    logic [AW:0]         w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;

    assign w_push_req = bus.sample_valid_i && enable_i;
    assign w_push     = w_push_req && (!w_fifo_full || w_pop);
    assign w_drop     = w_push_req && !w_push;
    assign w_can_tx   = (gap_q >= c_gap) && !bus.tx_busy_i;
    assign w_last     = (smp_q == c_last);

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push_i   (w_push),
        .data_i   (bus.sample_i),
        .pop_i    (w_pop),
        .data_o   (w_fifo_data),
        .count_o  (w_fifo_count),
        .full_o   (w_fifo_full),
        .empty_o  (w_fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame only starts once all of its samples are buffered, so the
    // pops issued on entry to each SHI never find the FIFO empty.
    always_comb begin
        state_d = state_q;
        w_fire  = 1'b0;
        w_pop   = 1'b0;
        w_byte  = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && (w_fifo_count >= c_frame_n)) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                w_byte = SYNC_BYTE;
                if (w_can_tx) begin
                    w_fire  = 1'b1;
                    state_d = ST_SEQ;
                end
            end
            ST_SEQ: begin
                w_byte = seq_q;
                if (w_can_tx) begin
                    w_fire  = 1'b1;
                    w_pop   = 1'b1;
                    state_d = ST_SHI;
                end
            end
            ST_SHI: begin
                w_byte = sample_q[SAMPLE_W-1 -: 8];
                if (w_can_tx) begin
                    w_fire  = 1'b1;
                    state_d = ST_SLO;
                end
            end
            ST_SLO: begin
                w_byte = sample_q[7:0];
                if (w_can_tx) begin
                    w_fire = 1'b1;
                    if (w_last) begin
                        state_d = ST_CSUM;
                    end else begin
                        w_pop   = 1'b1;
                        state_d = ST_SHI;
                    end
                end
            end
            ST_CSUM: begin
                w_byte = csum_q;
                if (w_can_tx) begin
                    w_fire  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sample_q   <= '0;
            seq_q      <= 8'h00;
            csum_q     <= 8'h00;
            smp_q      <= '0;
            gap_q      <= c_gap;
            tx_rdy_q   <= 1'b0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            tx_rdy_q <= w_fire;
            if (w_fire) begin
                tx_data_q <= w_byte;
                gap_q     <= GW'(1);
            end else if (gap_q < c_gap) begin
                gap_q <= gap_q + GW'(1);
            end

            if (w_pop && !w_fifo_empty) begin
                sample_q <= w_fifo_data;
            end

            // Checksum restarts from zero so the sync byte folds in like any other.
            if (w_fire) begin
                csum_q <= (state_q == ST_CSUM) ? 8'h00 : (csum_q ^ w_byte);
            end
            if (w_fire && (state_q == ST_CSUM)) begin
                seq_q <= seq_q + 8'h01;
            end

            if (w_fire && (state_q == ST_HDR)) begin
                smp_q <= '0;
            end else if (w_fire && (state_q == ST_SLO)) begin
                smp_q <= smp_q + SW'(1);
            end

            if (w_drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 8'hFF) begin
                    drop_q <= drop_q + 8'h01;
                end
            end
        end
    end

    assign bus.tx_data_rdy_o = tx_rdy_q;
    assign bus.tx_data_o     = tx_data_q;
    assign overflow_o        = overflow_q;
    assign drop_count_o      = drop_q;
    assign frame_active_o    = (state_q != ST_IDLE);

endmodule

`default_nettype wire
